// File: rtl/ring_sldu_port.sv
// SLDU-side endpoint of the inter-cluster ring: configures the router, then
// streams len beats out to the ring and collects len beats back into a one-entry buffer.
module ring_sldu_port #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_dir_i,
  input  logic                 req_bypass_i,
  input  logic [CntWidth-1:0]  req_len_i,
  output logic                 conf_valid_o,
  output logic                 dir_o,
  output logic                 bypass_o,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DataWidth-1:0] ring_data_o,
  output logic                 ring_valid_o,
  input  logic                 ring_ready_i,
  input  logic [DataWidth-1:0] ring_data_i,
  input  logic                 ring_valid_i,
  output logic                 ring_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 done_o,
  output logic                 busy_o
);

  // state | meaning
  // IDLE  | waiting for a request
  // CONF  | one-cycle router configuration pulse
  // XFER  | streaming tx beats out and rx beats in
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, CONF, XFER, DONE} state_e;

  state_e                state_q, state_d;
  logic                  dir_q, bypass_q;
  logic [CntWidth-1:0]   len_q, tx_cnt_q, rx_cnt_q;
  logic [DataWidth-1:0]  rx_q;
  logic                  rx_vq;

  logic in_xfer, tx_active, rx_active, tx_hs, rx_load, req_accept, xfer_done;

  assign in_xfer    = (state_q == XFER);
  assign tx_active  = in_xfer && (tx_cnt_q != len_q);
  assign rx_active  = in_xfer && (rx_cnt_q != len_q);
  assign req_accept = (state_q == IDLE) && req_valid_i;

  assign ring_data_o  = tx_data_i;
  assign ring_valid_o = tx_valid_i && tx_active;
  assign tx_ready_o   = ring_ready_i && tx_active;
  assign ring_ready_o = rx_active && (!rx_vq || rx_ready_i);
  assign rx_valid_o   = rx_vq;
  assign rx_data_o    = rx_q;
  assign dir_o        = dir_q;
  assign bypass_o     = bypass_q;

  assign tx_hs   = ring_valid_o && ring_ready_i;
  assign rx_load = ring_valid_i && ring_ready_o;

  // The last rx beat draining this cycle counts as drained, saving a cycle.
  assign xfer_done = (tx_cnt_q == len_q) && (rx_cnt_q == len_q) && (!rx_vq || rx_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid_i) state_d = CONF;
      CONF: state_d = (bypass_q || (len_q == '0)) ? DONE : XFER;
      XFER: if (xfer_done) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE);
    conf_valid_o = (state_q == CONF);
    done_o       = (state_q == DONE);
    busy_o       = (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q    <= 1'b0;
      bypass_q <= 1'b0;
      len_q    <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      rx_q     <= '0;
      rx_vq    <= 1'b0;
    end else if (req_accept) begin
      dir_q    <= req_dir_i;
      bypass_q <= req_bypass_i;
      len_q    <= req_len_i;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      rx_vq    <= 1'b0;
    end else begin
      if (tx_hs) tx_cnt_q <= tx_cnt_q + CntWidth'(1);
      if (rx_load) begin
        rx_q     <= ring_data_i;
        rx_vq    <= 1'b1;
        rx_cnt_q <= rx_cnt_q + CntWidth'(1);
      end else if (rx_ready_i && rx_vq) begin
        rx_vq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ring_sldu_port.sv
// Self-checking bench for ring_sldu_port: table of transfer vectors with a
// tx/rx scoreboard, plus reset and reset-mid-transfer sequences.
module tb_ring_sldu_port;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o, req_dir_i = 1'b0, req_bypass_i = 1'b0;
  logic [15:0] req_len_i = '0;
  logic        conf_valid_o, dir_o, bypass_o;
  logic [63:0] tx_data_i = '0, ring_data_o, ring_data_i = '0, rx_data_o;
  logic        tx_valid_i = 1'b0, tx_ready_o, ring_valid_o, ring_ready_i = 1'b0;
  logic        ring_valid_i = 1'b0, ring_ready_o, rx_valid_o, rx_ready_i = 1'b0;
  logic        done_o, busy_o;

  ring_sldu_port dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_dir_i(req_dir_i),
    .req_bypass_i(req_bypass_i), .req_len_i(req_len_i),
    .conf_valid_o(conf_valid_o), .dir_o(dir_o), .bypass_o(bypass_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .ring_data_o(ring_data_o), .ring_valid_o(ring_valid_o), .ring_ready_i(ring_ready_i),
    .ring_data_i(ring_data_i), .ring_valid_i(ring_valid_i), .ring_ready_o(ring_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        dir;
    logic        byp;
    logic [15:0] len;
    int          offer;
    int          stall_lo;
    int          stall_hi;
    int          exp_done;
    int          exp_tx;
    int          exp_rx;
    logic        hold;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] tx_exp_q[$];
  logic [63:0] rx_exp_q[$];
  logic [63:0] base = 64'hA0;
  int checks = 0, failures = 0;
  int rel, tx_idx, ring_idx, tx_hs, rx_acc, offer, stall_lo, stall_hi;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, then monitor handshakes mid-cycle.
  task automatic step(input logic rv);
    @(posedge clk_i);
    #1;
    req_valid_i  = rv;
    tx_valid_i   = 1'b1;
    tx_data_i    = base + 64'(tx_idx);
    ring_ready_i = 1'b1;
    ring_valid_i = (ring_idx < offer);
    ring_data_i  = base + 64'(ring_idx);
    rx_ready_i   = !(rel >= stall_lo && rel < stall_hi);
    @(negedge clk_i);
    if (ring_valid_o && ring_ready_i) begin
      tx_hs++;
      tx_idx++;
      if (tx_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected actual=%0h required=none", ring_data_o);
      end else chk("tx_data", ring_data_o, tx_exp_q.pop_front());
    end
    if (ring_valid_i && ring_ready_o) begin
      rx_exp_q.push_back(ring_data_i);
      ring_idx++;
      rx_acc++;
    end
    if (rx_valid_o && rx_ready_i) begin
      if (rx_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rx_unexpected actual=%0h required=none", rx_data_o);
      end else chk("rx_data", rx_data_o, rx_exp_q.pop_front());
    end
  endtask

  task automatic start_vec(input vec_t v);
    tx_idx = 0; ring_idx = 0; tx_hs = 0; rx_acc = 0;
    offer = v.offer; stall_lo = v.stall_lo; stall_hi = v.stall_hi;
    tx_exp_q.delete(); rx_exp_q.delete();
    for (int i = 0; i < v.exp_tx; i++) tx_exp_q.push_back(base + 64'(i));
    req_dir_i = v.dir; req_bypass_i = v.byp; req_len_i = v.len;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int done_rel, conf_extra;
    start_vec(v);
    rel = 0; step(1'b1);
    chk($sformatf("v%0d_req_ready", id), req_ready_o, 1'b1);
    rel = 1; step(v.hold);
    chk($sformatf("v%0d_conf_valid", id), conf_valid_o, 1'b1);
    chk($sformatf("v%0d_dir", id), dir_o, v.dir);
    chk($sformatf("v%0d_bypass", id), bypass_o, v.byp);
    done_rel = -1; conf_extra = 0;
    for (int r = 2; r < 60; r++) begin
      rel = r; step(v.hold);
      if (conf_valid_o) conf_extra++;
      if (v.stall_hi > 0 && r == 3) chk($sformatf("v%0d_rr_stall", id), ring_ready_o, 1'b0);
      if (done_o) begin done_rel = r; break; end
    end
    chk($sformatf("v%0d_done_cycle", id), 64'(done_rel), 64'(v.exp_done));
    chk($sformatf("v%0d_conf_repeat", id), 64'(conf_extra), 64'd0);
    chk($sformatf("v%0d_tx_count", id), 64'(tx_hs), 64'(v.exp_tx));
    chk($sformatf("v%0d_rx_count", id), 64'(rx_acc), 64'(v.exp_rx));
    chk($sformatf("v%0d_rx_left", id), 64'(rx_exp_q.size()), 64'd0);
    rel = done_rel + 1; step(1'b0);
    chk($sformatf("v%0d_idle_ready", id), req_ready_o, 1'b1);
    chk($sformatf("v%0d_idle_busy", id), busy_o, 1'b0);
    chk($sformatf("v%0d_idle_ring_ready", id), ring_ready_o, 1'b0);
    chk($sformatf("v%0d_idle_dir_hold", id), dir_o, v.dir);
    chk($sformatf("v%0d_idle_byp_hold", id), bypass_o, v.byp);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{1'b1, 1'b0, 16'd4, 4, 0, 0, 7, 4, 4, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'd3, 3, 2, 7, 10, 3, 3, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'd5, 5, 0, 0, 2, 0, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'd0, 3, 0, 0, 2, 0, 0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'd4, 6, 0, 0, 7, 4, 4, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'd1, 1, 0, 0, 4, 1, 1, 1'b0};

    offer = 0; stall_lo = 0; stall_hi = 0; rel = 0;
    tx_idx = 0; ring_idx = 0; tx_hs = 0; rx_acc = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_conf", conf_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_dir", dir_o, 1'b0);
    chk("rst_bypass", bypass_o, 1'b0);
    chk("rst_ring_valid", ring_valid_o, 1'b0);
    chk("rst_tx_ready", tx_ready_o, 1'b0);
    chk("rst_ring_ready", ring_ready_o, 1'b0);
    chk("rst_rx_valid", rx_valid_o, 1'b0);
    rst_ni = 1'b1;
    step(1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_ring_valid", ring_valid_o, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset after 3 of 8 beats: back to IDLE at once, nothing completes.
    rv = '{1'b1, 1'b0, 16'd8, 8, 0, 0, 0, 8, 8, 1'b0};
    start_vec(rv);
    rel = 0; step(1'b1);
    rel = 1; step(1'b0);
    for (int r = 2; r < 20 && tx_hs < 3; r++) begin
      rel = r; step(1'b0);
    end
    chk("mid_tx_count", 64'(tx_hs), 64'd3);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ring_ready", ring_ready_o, 1'b0);
    chk("mid_rst_req_ready", req_ready_o, 1'b1);
    step(1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    rst_ni = 1'b1;
    step(1'b0);
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_done", done_o, 1'b0);
    chk("post_rst_ring_ready", ring_ready_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
